// File: rtl/cpu_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pio_pkg
// Description : Shared constants for the key/switch input PIO: register word
//               addresses, edge-mode encodings and the debounce counter width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pio_pkg;

    // Register word addresses on the Avalon-MM slave
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Edge-capture event selection
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Counter must hold values up to DEBOUNCE_CYCLES without wrapping
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pio_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : pio_debounce_bit
// Description : One input bit: metastability synchroniser followed by a
//               hold-time debouncer. A new level is accepted only after it
//               has been seen for DEBOUNCE_CYCLES consecutive clocks.
// Ports       : clk, reset_n (async, active-low)
//               in_bit  - asynchronous external input
//               stable  - debounced, synchronous level
// Revision    : 1.0 - initial release
// ============================================================================
module pio_debounce_bit
    import cpu_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    output logic stable
);

    localparam int             c_cnt_w    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   r_stable;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign stable = r_stable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_bit};
        end
    end

    // Any return to the accepted level restarts the count, so only an
    // uninterrupted run of DEBOUNCE_CYCLES clocks changes the output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (w_sync == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cpu_pio_key_irq.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pio_key_irq
// Description : Avalon-MM input PIO for push-buttons/switches. Per-bit
//               synchroniser and debouncer, edge capture with
//               write-one-to-clear, masked level interrupt.
// Ports       : clk, reset_n (async, active-low)
//               address[1:0]  0 data, 1 reserved, 2 interruptmask, 3 edgecapture
//               chipselect, write_n, writedata[31:0] - slave write side
//               readdata[31:0] - registered read data, zero-extended
//               in_port[WIDTH-1:0] - asynchronous external inputs
//               irq - high while any (edgecapture & mask) bit is set
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_pio_key_irq
    import cpu_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter int               EDGE_MODE       = 1,
    parameter logic [WIDTH-1:0] IRQ_MASK_RESET  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      r_readdata;
    logic             w_wr;
    logic             w_unused_wdata;

    // Upper write-data bits beyond WIDTH carry no register state
    assign w_unused_wdata = ^writedata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pio_debounce_bit #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clk    (clk),
                .reset_n(reset_n),
                .in_bit (in_port[i]),
                .stable (w_stable[i])
            );
        end
    endgenerate

    // stable_d resets to 0 alongside stable, so reset release itself
    // never looks like a transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= '0;
        end else begin
            r_stable_d <= w_stable;
        end
    end

    generate
        if (EDGE_MODE == EDGE_RISING) begin : g_edge_rise
            assign w_event = w_stable & ~r_stable_d;
        end else if (EDGE_MODE == EDGE_FALLING) begin : g_edge_fall
            assign w_event = ~w_stable & r_stable_d;
        end else begin : g_edge_any
            assign w_event = w_stable ^ r_stable_d;
        end
    endgenerate

    assign w_wr  = chipselect & ~write_n;
    assign w_clr = (w_wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= IRQ_MASK_RESET;
        end else if (w_wr && address == ADDR_MASK) begin
            r_mask <= writedata[WIDTH-1:0];
        end
    end

    // New events are OR-ed in after the clear so a same-cycle W1C cannot
    // swallow an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_event;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            case (address)
                ADDR_DATA: r_readdata <= 32'(w_stable);
                ADDR_MASK: r_readdata <= 32'(r_mask);
                ADDR_EDGE: r_readdata <= 32'(r_edge);
                default:   r_readdata <= '0;
            endcase
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_edge & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_cpu_pio_key_irq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_pio_key_irq
// Description : Self-checking bench for cpu_pio_key_irq (WIDTH=4,
//               DEBOUNCE_CYCLES=8, EDGE_MODE=falling, SYNC_STAGES=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_pio_key_irq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  in_port;
    logic        irq;

    int n_checks;
    int n_errors;

    cpu_pio_key_irq #(
        .WIDTH          (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .EDGE_MODE      (1),
        .IRQ_MASK_RESET (4'h0)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  in_val;
        int          hold;
        logic        wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t vecs[13];

    // Inputs change and outputs are sampled 1 time unit after a rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // Starting point for every vector: stable=F, mask=0, edgecapture=0
        vecs[0]  = '{4'hF,  2, 1'b0, 2'd0, 32'h0, 2'd0, 32'hF, 1'b0, "tbl_data_idle"};
        vecs[1]  = '{4'hF,  2, 1'b1, 2'd2, 32'h1, 2'd2, 32'h1, 1'b0, "tbl_mask_wr1"};
        vecs[2]  = '{4'hE, 14, 1'b0, 2'd0, 32'h0, 2'd3, 32'h1, 1'b1, "tbl_bit0_fall"};
        vecs[3]  = '{4'hE,  2, 1'b0, 2'd0, 32'h0, 2'd0, 32'hE, 1'b1, "tbl_data_E"};
        vecs[4]  = '{4'hE,  2, 1'b1, 2'd3, 32'h1, 2'd3, 32'h0, 1'b0, "tbl_w1c_bit0"};
        vecs[5]  = '{4'hA, 14, 1'b0, 2'd0, 32'h0, 2'd3, 32'h4, 1'b0, "tbl_bit2_masked"};
        vecs[6]  = '{4'hA,  2, 1'b1, 2'd2, 32'h4, 2'd2, 32'h4, 1'b1, "tbl_unmask_bit2"};
        vecs[7]  = '{4'hA,  2, 1'b1, 2'd1, 32'hF, 2'd1, 32'h0, 1'b1, "tbl_rsvd_wr"};
        vecs[8]  = '{4'hA,  2, 1'b1, 2'd0, 32'h0, 2'd3, 32'h4, 1'b1, "tbl_data_wr_ign"};
        vecs[9]  = '{4'hF, 14, 1'b0, 2'd0, 32'h0, 2'd3, 32'h4, 1'b1, "tbl_rise_no_cap"};
        vecs[10] = '{4'hF,  2, 1'b1, 2'd3, 32'hF, 2'd3, 32'h0, 1'b0, "tbl_w1c_all"};
        vecs[11] = '{4'hF,  2, 1'b0, 2'd0, 32'h0, 2'd0, 32'hF, 1'b0, "tbl_data_F"};
        vecs[12] = '{4'hF,  2, 1'b1, 2'd2, 32'hF, 2'd2, 32'hF, 1'b0, "tbl_mask_all"};

        // 1: reset with inputs released (high)
        tick(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        address = 2'd2;
        reset_n = 1'b1;
        tick(1);
        check("rst_mask_read", readdata, 32'h0);

        // Let the post-reset 0->F rise settle (not captured in falling mode)
        address = 2'd3;
        tick(14);
        check("rst_no_edge", readdata, 32'h0);

        // Table-driven main function
        for (int i = 0; i < 13; i++) begin
            in_port = vecs[i].in_val;
            if (vecs[i].wr) do_write(vecs[i].waddr, vecs[i].wdata);
            address = vecs[i].raddr;
            tick(vecs[i].hold);
            check(vecs[i].name, readdata, vecs[i].exp_rd);
            check({vecs[i].name, "_irq"}, {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // 2/3: exact latency of a clean bit0 fall, then W1C
        do_write(2'd2, 32'h1);
        address = 2'd0;
        in_port = 4'hE;
        tick(10);
        check("lat_data_before", readdata, 32'hF);
        check("lat_irq_before", {31'd0, irq}, 32'h0);
        tick(1);
        check("lat_data_after", readdata, 32'hE);
        check("lat_irq_after", {31'd0, irq}, 32'h1);
        do_write(2'd3, 32'h1);
        check("w1c_irq_next", {31'd0, irq}, 32'h0);
        address = 2'd3;
        tick(1);
        check("w1c_edge_zero", readdata, 32'h0);

        // 2: glitch shorter than the debounce window is ignored
        in_port = 4'hF;
        tick(14);
        in_port = 4'hE;
        tick(5);
        in_port = 4'hF;
        address = 2'd0;
        tick(14);
        check("glitch_data", readdata, 32'hF);
        address = 2'd3;
        tick(1);
        check("glitch_edge", readdata, 32'h0);

        // 5: W1C on the same clock as a new bit0 fall event
        in_port = 4'hE;
        tick(10);
        do_write(2'd3, 32'h1);
        address = 2'd3;
        tick(1);
        check("collide_edge", readdata, 32'h1);
        check("collide_irq", {31'd0, irq}, 32'h1);
        do_write(2'd3, 32'hF);
        in_port = 4'hF;
        tick(14);

        // 6: reset while bit1 is mid-debounce
        in_port = 4'hD;
        address = 2'd0;
        tick(4);
        reset_n = 1'b0;
        in_port = 4'hF;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        check("mrst_data_zero", readdata, 32'h0);
        tick(9);
        check("mrst_data_before", readdata, 32'h0);
        tick(1);
        check("mrst_data_F", readdata, 32'hF);
        address = 2'd3;
        tick(3);
        check("mrst_no_edge", readdata, 32'h0);
        check("mrst_irq", {31'd0, irq}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
